// File: rtl/mipi_pkg.sv
// rtl/mipi_pkg.sv - shared constants, state encoding and helpers for the D-PHY byte aligner
package mipi_pkg;

  // HS sync byte that starts every high-speed burst on a data lane
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // LP line states as {lp_p, lp_n}
  localparam logic [1:0] LP11 = 2'b11;  // stop
  localparam logic [1:0] LP01 = 2'b01;  // HS request
  localparam logic [1:0] LP00 = 2'b00;  // bridge
  localparam logic [1:0] LP10 = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STOP    = 3'd1,
    HS_REQ  = 3'd2,
    HUNT    = 3'd3,
    ALIGNED = 3'd4,
    WAIT_LP = 3'd5
  } state_e;

  // number of set bits in a byte, used as the Hamming distance of an xor
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mipi_lp_sync.sv
// rtl/mipi_lp_sync.sv - two-flop synchroniser for the asynchronous LP receiver pair
module mipi_lp_sync (
  input  logic phy_clk,
  input  logic resetb,
  input  logic lp_p_i,
  input  logic lp_n_i,
  output logic lp_p_o,
  output logic lp_n_o
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  // two-stage capture; resets to LP11 so the lane looks stopped out of reset
  always_ff @(posedge phy_clk) begin
    if (!resetb) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {lp_p_i, lp_n_i};
      sync_q <= meta_q;
    end
  end

  assign lp_p_o = sync_q[1];
  assign lp_n_o = sync_q[0];

endmodule

// File: rtl/mipi_byte_aligner.sv
// rtl/mipi_byte_aligner.sv - D-PHY data-lane aligner: LP entry tracking, HS sync hunt, aligned byte output
module mipi_byte_aligner
  import mipi_pkg::*;
#(
  parameter int HUNT_TIMEOUT = 64,
  parameter int SYNC_ERR_TOL = 0
) (
  input  logic        phy_clk,
  input  logic        resetb,
  input  logic        enable_i,
  input  logic        md_polarity_i,
  input  logic [7:0]  raw_data_i,
  input  logic        lp_p_i,
  input  logic        lp_n_i,
  output logic [7:0]  data_o,
  output logic        we_o,
  output logic [2:0]  aligned_offset_o,
  output logic [31:0] sync_count_o,
  output logic [15:0] timeout_count_o
);

  localparam logic [15:0] HUNT_LAST = 16'(HUNT_TIMEOUT - 1);
  localparam logic [3:0]  SYNC_TOL  = 4'(SYNC_ERR_TOL);

  logic        lp_p_s;
  logic        lp_n_s;
  logic [1:0]  lp;

  logic [7:0]  word_d;
  logic [7:0]  prev_q;
  logic [15:0] win;

  logic        hit_d;
  logic [2:0]  hit_k_d;
  logic [7:0]  byte_d;
  logic [31:0] sync_cnt_d;
  logic [15:0] to_cnt_d;

  state_e      state_q;
  logic [15:0] hunt_cnt_q;
  logic [7:0]  data_q;
  logic        we_q;
  logic [2:0]  off_q;
  logic [31:0] sync_cnt_q;
  logic [15:0] to_cnt_q;

  mipi_lp_sync u_lp_sync (
    .phy_clk (phy_clk),
    .resetb  (resetb),
    .lp_p_i  (lp_p_i),
    .lp_n_i  (lp_n_i),
    .lp_p_o  (lp_p_s),
    .lp_n_o  (lp_n_s)
  );

  assign lp = {lp_p_s, lp_n_s};

  // lane polarity swap is undone before anything looks at the bits
  assign word_d = raw_data_i ^ {8{md_polarity_i}};

  // bit0 is earliest, so the older word sits in the low half of the window
  assign win    = {word_d, prev_q};
  assign byte_d = win[off_q +: 8];

  assign sync_cnt_d = sync_cnt_q + 32'd1;
  assign to_cnt_d   = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;

  // keep one word of history so a sync straddling a word boundary is visible
  always_ff @(posedge phy_clk) begin
    if (!resetb) begin
      prev_q <= 8'h00;
    end else begin
      prev_q <= word_d;
    end
  end

  // scan offsets high to low so the lowest matching offset is what remains
  always_comb begin
    hit_d   = 1'b0;
    hit_k_d = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (popcount8(win[k +: 8] ^ SYNC_BYTE) <= SYNC_TOL) begin
        hit_d   = 1'b1;
        hit_k_d = 3'(k);
      end
    end
  end

  // lane state machine with registered byte output, we and counters
  always_ff @(posedge phy_clk) begin
    if (!resetb) begin
      state_q    <= IDLE;
      hunt_cnt_q <= 16'd0;
      data_q     <= 8'h00;
      we_q       <= 1'b0;
      off_q      <= 3'd0;
      sync_cnt_q <= 32'd0;
      to_cnt_q   <= 16'd0;
    end else if (!enable_i) begin
      // disabled lane drops to IDLE; data and counters keep their values
      state_q <= IDLE;
      we_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lp == LP11) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (lp == LP01) begin
            state_q <= HS_REQ;
          end else if (lp != LP11) begin
            state_q <= IDLE;
          end
        end
        HS_REQ: begin
          if (lp == LP00) begin
            state_q    <= HUNT;
            hunt_cnt_q <= 16'd0;
          end else if (lp == LP11) begin
            state_q <= STOP;
          end else if (lp == LP10) begin
            state_q <= IDLE;
          end
        end
        HUNT: begin
          // a stop during the hunt aborts quietly; it is not a timeout
          if (lp == LP11) begin
            state_q <= STOP;
          end else if (hit_d) begin
            off_q      <= hit_k_d;
            sync_cnt_q <= sync_cnt_d;
            state_q    <= ALIGNED;
          end else if (hunt_cnt_q == HUNT_LAST) begin
            to_cnt_q <= to_cnt_d;
            state_q  <= WAIT_LP;
          end else begin
            hunt_cnt_q <= hunt_cnt_q + 16'd1;
          end
        end
        ALIGNED: begin
          // end of burst: bytes still in the window are trailer garbage
          if (lp == LP11) begin
            state_q <= STOP;
          end else begin
            data_q <= byte_d;
            we_q   <= 1'b1;
          end
        end
        WAIT_LP: begin
          if (lp == LP11) begin
            state_q <= STOP;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_o           = data_q;
  assign we_o             = we_q;
  assign aligned_offset_o = off_q;
  assign sync_count_o     = sync_cnt_q;
  assign timeout_count_o  = to_cnt_q;

endmodule

// File: tb/tb_mipi_byte_aligner.sv
// tb/tb_mipi_byte_aligner.sv - directed self-checking bench for mipi_byte_aligner
module tb_mipi_byte_aligner;
  import mipi_pkg::*;

  logic        phy_clk = 1'b0;
  logic        resetb;
  logic        enable_i;
  logic        md_polarity_i;
  logic [7:0]  raw_data_i;
  logic        lp_p_i;
  logic        lp_n_i;

  logic [7:0]  data_o;
  logic        we_o;
  logic [2:0]  aligned_offset_o;
  logic [31:0] sync_count_o;
  logic [15:0] timeout_count_o;

  logic [7:0]  t1_data;
  logic        t1_we;
  logic [2:0]  t1_off;
  logic [31:0] t1_sync;
  logic [15:0] t1_to;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         we_cyc[$];

  logic [7:0] payload[0:15];
  logic [7:0] segw[0:31];
  int         nseg;

  always #5 phy_clk = ~phy_clk;

  always @(posedge phy_clk) cyc <= cyc + 1;

  always @(negedge phy_clk) begin
    if (we_o) begin
      q0.push_back(data_o);
      we_cyc.push_back(cyc);
    end
    if (t1_we) q1.push_back(t1_data);
  end

  mipi_byte_aligner dut (
    .phy_clk          (phy_clk),
    .resetb           (resetb),
    .enable_i         (enable_i),
    .md_polarity_i    (md_polarity_i),
    .raw_data_i       (raw_data_i),
    .lp_p_i           (lp_p_i),
    .lp_n_i           (lp_n_i),
    .data_o           (data_o),
    .we_o             (we_o),
    .aligned_offset_o (aligned_offset_o),
    .sync_count_o     (sync_count_o),
    .timeout_count_o  (timeout_count_o)
  );

  mipi_byte_aligner #(.SYNC_ERR_TOL(1)) dut_t1 (
    .phy_clk          (phy_clk),
    .resetb           (resetb),
    .enable_i         (enable_i),
    .md_polarity_i    (md_polarity_i),
    .raw_data_i       (raw_data_i),
    .lp_p_i           (lp_p_i),
    .lp_n_i           (lp_n_i),
    .data_o           (t1_data),
    .we_o             (t1_we),
    .aligned_offset_o (t1_off),
    .sync_count_o     (t1_sync),
    .timeout_count_o  (t1_to)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] w, input logic [1:0] lp);
    raw_data_i = w ^ {8{md_polarity_i}};
    {lp_p_i, lp_n_i} = lp;
    @(posedge phy_clk);
    #1;
  endtask

  task automatic goto_hunt();
    repeat (4) send(8'h00, LP11);
    repeat (3) send(8'h00, LP01);
    repeat (4) send(8'h00, LP00);
  endtask

  task automatic build_seg(input int k, input logic [7:0] sb, input int npay);
    logic [255:0] bits;
    int nbits;
    bits = '0;
    bits[k +: 8] = sb;
    for (int i = 0; i < npay; i++) bits[k + 8 + 8*i +: 8] = payload[i];
    nbits = k + 8 + 8*npay;
    nseg = (nbits + 7) / 8 + 1;
    for (int i = 0; i < nseg; i++) segw[i] = bits[8*i +: 8];
  endtask

  task automatic chk_bytes0(input string tag, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), (i < q0.size()) ? {24'h0, q0[i]} : 32'hFFFF_FFFF, {24'h0, payload[i]});
  endtask

  task automatic std_burst(input int k, input int exp_sync, input string tag);
    int det;
    det = 0;
    q0.delete();
    we_cyc.delete();
    goto_hunt();
    build_seg(k, SYNC_BYTE, 4);
    for (int i = 0; i < nseg; i++) begin
      send(segw[i], (i >= 4) ? LP11 : LP00);
      if (i == 1) det = cyc;
    end
    repeat (4) send(8'h00, LP11);
    chk($sformatf("%s_off", tag), {29'h0, aligned_offset_o}, k);
    chk($sformatf("%s_sync", tag), sync_count_o, exp_sync);
    chk($sformatf("%s_nbytes", tag), q0.size(), 4);
    chk_bytes0(tag, 4);
    chk($sformatf("%s_lat", tag), (we_cyc.size() > 0) ? we_cyc[0] : -1, det + 1);
  endtask

  initial begin
    payload = '{8'h2B, 8'h10, 8'h00, 8'h55, 8'hA5, 8'h3C, 8'hFF, 8'h01,
                8'h7E, 8'h80, 8'hC3, 8'h99, 8'h0F, 8'hF0, 8'h66, 8'hE7};
    resetb = 1'b0;
    enable_i = 1'b1;
    md_polarity_i = 1'b0;
    raw_data_i = 8'h00;
    {lp_p_i, lp_n_i} = LP11;
    repeat (3) @(posedge phy_clk);
    #1;
    chk("rst_data", {24'h0, data_o}, 0);
    chk("rst_we", {31'h0, we_o}, 0);
    chk("rst_off", {29'h0, aligned_offset_o}, 0);
    chk("rst_sync", sync_count_o, 0);
    chk("rst_to", {16'h0, timeout_count_o}, 0);
    resetb = 1'b1;

    for (int k = 0; k < 8; k++) std_burst(k, k + 1, $sformatf("sweep%0d", k));

    md_polarity_i = 1'b1;
    std_burst(3, 9, "pol");
    md_polarity_i = 1'b0;

    q0.delete();
    goto_hunt();
    repeat (62) send(8'h00, LP00);
    chk("to_before", {16'h0, timeout_count_o}, 0);
    send(8'h00, LP00);
    chk("to_at", {16'h0, timeout_count_o}, 1);
    repeat (3) send(8'h00, LP01);
    repeat (4) send(8'h00, LP00);
    build_seg(0, SYNC_BYTE, 4);
    for (int i = 0; i < nseg; i++) send(segw[i], LP00);
    repeat (4) send(8'h00, LP00);
    chk("wait_sync", sync_count_o, 9);
    chk("wait_nowe", q0.size(), 0);
    chk("wait_to", {16'h0, timeout_count_o}, 1);
    std_burst(5, 10, "relock");

    q0.delete();
    q1.delete();
    goto_hunt();
    build_seg(0, 8'hB9, 4);
    for (int i = 0; i < nseg; i++) send(segw[i], LP00);
    repeat (70) send(8'h00, LP00);
    chk("tol0_to", {16'h0, timeout_count_o}, 2);
    chk("tol0_sync", sync_count_o, 10);
    chk("tol0_nowe", q0.size(), 0);
    chk("tol1_off", {29'h0, t1_off}, 0);
    chk("tol1_sync", t1_sync, 11);
    chk("tol1_n", {31'h0, q1.size() >= 4}, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tol1_b%0d", i), (i < q1.size()) ? {24'h0, q1[i]} : 32'hFFFF_FFFF, {24'h0, payload[i]});
    repeat (4) send(8'h00, LP11);

    q0.delete();
    goto_hunt();
    build_seg(6, SYNC_BYTE, 16);
    for (int i = 0; i < nseg; i++) begin
      send(segw[i], (i >= 10) ? LP11 : LP00);
      if (i == 12) chk("end_we_drop", {31'h0, we_o}, 0);
    end
    repeat (4) send(8'h00, LP11);
    chk("end_nbytes", q0.size(), 10);
    chk_bytes0("end", 10);
    chk("end_sync", sync_count_o, 11);
    std_burst(1, 12, "after_end");

    q0.delete();
    goto_hunt();
    build_seg(4, SYNC_BYTE, 16);
    for (int i = 0; i < nseg; i++) begin
      enable_i = (i != 6);
      send(segw[i], LP00);
      if (i == 5) chk("en_pre_data", {24'h0, data_o}, {24'h0, payload[3]});
      if (i == 6) begin
        chk("en_we", {31'h0, we_o}, 0);
        chk("en_data_hold", {24'h0, data_o}, {24'h0, payload[3]});
        chk("en_sync", sync_count_o, 13);
        chk("en_to", {16'h0, timeout_count_o}, 2);
      end
    end
    enable_i = 1'b1;
    repeat (4) send(8'h00, LP11);
    chk("en_nbytes", q0.size(), 4);

    q0.delete();
    goto_hunt();
    build_seg(7, SYNC_BYTE, 16);
    for (int i = 0; i < nseg; i++) begin
      resetb = (i != 5);
      send(segw[i], LP00);
      if (i == 5) begin
        chk("mrst_data", {24'h0, data_o}, 0);
        chk("mrst_we", {31'h0, we_o}, 0);
        chk("mrst_off", {29'h0, aligned_offset_o}, 0);
        chk("mrst_sync", sync_count_o, 0);
        chk("mrst_to", {16'h0, timeout_count_o}, 0);
      end
    end
    resetb = 1'b1;
    chk("mrst_nbytes", q0.size(), 3);
    std_burst(2, 1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
